// File: rtl/attack_phase_sequencer.sv
// Per-slot attack phase generator feeding AttackTable; one slot processed per clkena beat.
// Slot identity is delayed to line up with the table's 2-beat data latency.
module attack_phase_sequencer #(
  parameter int unsigned NUM_SLOTS = 18,
  parameter int unsigned PHASE_W   = 22
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clkena,
  input  logic [4:0]         slot,
  input  logic               key,
  input  logic [3:0]         ar,
  input  logic [3:0]         rks,
  output logic [PHASE_W-1:0] addr,
  output logic [4:0]         addr_slot,
  output logic               addr_valid,
  output logic               attack_done,
  output logic [4:0]         data_slot,
  output logic               data_valid
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ATTACK = 2'd1,
    ST_DONE   = 2'd2
  } stage_e;

  localparam logic [PHASE_W:0]   SUM_FULL   = {1'b0, {PHASE_W{1'b1}}};
  localparam logic [PHASE_W-1:0] PHASE_FULL = '1;

  logic [PHASE_W-1:0] phase_q [NUM_SLOTS];
  stage_e             stage_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] prev_key_q;

  logic [PHASE_W-1:0] addr_q, addr_d;
  logic [4:0]         addr_slot_q;
  logic               addr_valid_q, addr_valid_d;
  logic               attack_done_q, attack_done_d;
  logic [4:0]         mid_slot_q, data_slot_q;
  logic               mid_valid_q, data_valid_q;

  logic               slot_ok;
  logic [4:0]         idx;
  logic [PHASE_W-1:0] cur_phase;
  stage_e             cur_stage;
  logic               cur_prev_key;
  logic               key_edge;
  logic [6:0]         rate_sum;
  logic [5:0]         rate;
  logic [PHASE_W-1:0] step;
  logic [PHASE_W:0]   sum;

  logic [PHASE_W-1:0] ph_d;
  stage_e             st_d;
  logic               done_d;

  // Out-of-range slots read entry 0 but never write, so their lookup is harmless.
  assign slot_ok      = ({27'd0, slot} < NUM_SLOTS);
  assign idx          = slot_ok ? slot : '0;
  assign cur_phase    = phase_q[idx];
  assign cur_stage    = stage_q[idx];
  assign cur_prev_key = prev_key_q[idx];
  assign key_edge     = key & ~cur_prev_key;

  assign rate_sum = {1'b0, ar, 2'b00} + {3'b000, rks};
  assign rate     = (rate_sum > 7'd63) ? 6'd63 : rate_sum[5:0];
  assign step     = (ar == 4'd0) ? '0 : (PHASE_W'({1'b1, rate[1:0]}) << rate[5:2]);
  assign sum      = {1'b0, cur_phase} + {1'b0, step};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= '{default: '0};
      stage_q       <= '{default: ST_IDLE};
      prev_key_q    <= '0;
      addr_q        <= '0;
      addr_slot_q   <= '0;
      addr_valid_q  <= 1'b0;
      attack_done_q <= 1'b0;
      mid_slot_q    <= '0;
      mid_valid_q   <= 1'b0;
      data_slot_q   <= '0;
      data_valid_q  <= 1'b0;
    end else if (clkena) begin
      if (slot_ok) begin
        phase_q[idx]    <= ph_d;
        stage_q[idx]    <= st_d;
        prev_key_q[idx] <= key;
      end
      addr_q        <= addr_d;
      addr_slot_q   <= slot;
      addr_valid_q  <= addr_valid_d;
      attack_done_q <= attack_done_d;
      mid_slot_q    <= addr_slot_q;
      mid_valid_q   <= addr_valid_q;
      data_slot_q   <= mid_slot_q;
      data_valid_q  <= mid_valid_q;
    end
  end

  always_comb begin
    ph_d   = cur_phase;
    st_d   = cur_stage;
    done_d = 1'b0;
    if (key_edge && (ar != 4'd15)) begin
      ph_d = '0;
      st_d = ST_ATTACK;
    end else if (key_edge) begin
      ph_d   = PHASE_FULL;
      st_d   = ST_DONE;
      done_d = 1'b1;
    end else if (!key) begin
      st_d = ST_IDLE;
    end else if (cur_stage == ST_ATTACK) begin
      if (sum >= SUM_FULL) begin
        ph_d   = PHASE_FULL;
        st_d   = ST_DONE;
        done_d = 1'b1;
      end else begin
        ph_d = sum[PHASE_W-1:0];
      end
    end
  end

  always_comb begin
    addr_d        = '0;
    addr_valid_d  = 1'b0;
    attack_done_d = 1'b0;
    if (slot_ok) begin
      addr_d        = ph_d;
      addr_valid_d  = (st_d == ST_ATTACK) | done_d;
      attack_done_d = done_d;
    end
  end

  assign addr        = addr_q;
  assign addr_slot   = addr_slot_q;
  assign addr_valid  = addr_valid_q;
  assign attack_done = attack_done_q;
  assign data_slot   = data_slot_q;
  assign data_valid  = data_valid_q;

endmodule

// File: tb/tb_attack_phase_sequencer.sv
// Directed bench for attack_phase_sequencer: vector table plus multi-beat attack, reset and alignment sequences.
module tb_attack_phase_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clkena = 1'b0;
  logic [4:0]  slot = '0;
  logic        key = 1'b0;
  logic [3:0]  ar = '0;
  logic [3:0]  rks = '0;
  logic [21:0] addr;
  logic [4:0]  addr_slot;
  logic        addr_valid;
  logic        attack_done;
  logic [4:0]  data_slot;
  logic        data_valid;

  int pass_cnt = 0;
  int total_cnt = 0;

  attack_phase_sequencer #(.NUM_SLOTS(18), .PHASE_W(22)) dut (
    .clk(clk), .reset_n(reset_n), .clkena(clkena), .slot(slot), .key(key),
    .ar(ar), .rks(rks), .addr(addr), .addr_slot(addr_slot), .addr_valid(addr_valid),
    .attack_done(attack_done), .data_slot(data_slot), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  slot;
    logic        key;
    logic [3:0]  ar;
    logic [3:0]  rks;
    logic [21:0] addr;
    logic [4:0]  aslot;
    logic        valid;
    logic        done;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic beat(input logic en, input logic [4:0] s, input logic k,
                      input logic [3:0] a, input logic [3:0] r);
    clkena = en; slot = s; key = k; ar = a; rks = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [21:0] ea, input logic ev, input logic ed);
    chk({name, ".addr"}, 32'(addr), 32'(ea));
    chk({name, ".valid"}, 32'(addr_valid), 32'(ev));
    chk({name, ".done"}, 32'(attack_done), 32'(ed));
  endtask

  int          hist [200];
  int          nbeats;
  logic [4:0]  s_pick;
  logic        en_pick;
  logic [4:0]  exp_as, exp_ds;
  logic        exp_av, exp_dv;

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  1'b1, 4'd15, 4'd0,  22'h3FFFFF, 5'd5,  1'b1, 1'b1};
    vecs[1]  = '{1'b1, 5'd5,  1'b1, 4'd15, 4'd0,  22'h3FFFFF, 5'd5,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd9,  1'b1, 4'd3,  4'd0,  22'h3FFFFF, 5'd5,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'd20, 1'b1, 4'd8,  4'd0,  22'd0,      5'd20, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 5'd14, 1'b1, 4'd14, 4'd15, 22'd0,      5'd14, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 5'd14, 1'b1, 4'd14, 4'd15, 22'd229376, 5'd14, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 5'd14, 1'b1, 4'd14, 4'd15, 22'd458752, 5'd14, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5'd0,  1'b1, 4'd0,  4'd0,  22'd0,      5'd0,  1'b1, 1'b0};
    vecs[8]  = '{1'b1, 5'd0,  1'b1, 4'd0,  4'd0,  22'd0,      5'd0,  1'b1, 1'b0};
    vecs[9]  = '{1'b1, 5'd0,  1'b1, 4'd0,  4'd9,  22'd0,      5'd0,  1'b1, 1'b0};
    vecs[10] = '{1'b1, 5'd14, 1'b1, 4'd14, 4'd15, 22'd688128, 5'd14, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 5'd2,  1'b1, 4'd1,  4'd2,  22'd0,      5'd2,  1'b1, 1'b0};
    vecs[12] = '{1'b1, 5'd2,  1'b1, 4'd1,  4'd2,  22'd12,     5'd2,  1'b1, 1'b0};
    vecs[13] = '{1'b1, 5'd2,  1'b1, 4'd2,  4'd3,  22'd40,     5'd2,  1'b1, 1'b0};
    vecs[14] = '{1'b1, 5'd2,  1'b0, 4'd1,  4'd2,  22'd40,     5'd2,  1'b0, 1'b0};
    vecs[15] = '{1'b1, 5'd2,  1'b1, 4'd1,  4'd2,  22'd0,      5'd2,  1'b1, 1'b0};
    vecs[16] = '{1'b1, 5'd5,  1'b0, 4'd15, 4'd0,  22'h3FFFFF, 5'd5,  1'b0, 1'b0};
    vecs[17] = '{1'b1, 5'd5,  1'b1, 4'd15, 4'd0,  22'h3FFFFF, 5'd5,  1'b1, 1'b1};
    vecs[18] = '{1'b1, 5'd14, 1'b1, 4'd5,  4'd0,  22'd688256, 5'd14, 1'b1, 1'b0};

    // Reset held while clkena toggles, then idle beats with key low.
    #1;
    for (int i = 0; i < 6; i++) begin
      beat(1'(i % 2), 5'(i), 1'b0, 4'd8, 4'd0);
      chk_out("rst_hold", 22'd0, 1'b0, 1'b0);
      chk("rst_hold.dvalid", 32'(data_valid), 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      beat(1'b1, 5'(i), 1'b0, 4'd8, 4'd0);
      chk_out("idle", 22'd0, 1'b0, 1'b0);
      chk("idle.dvalid", 32'(data_valid), 32'd0);
    end

    for (int i = 0; i < 19; i++) begin
      beat(vecs[i].en, vecs[i].slot, vecs[i].key, vecs[i].ar, vecs[i].rks);
      chk_out($sformatf("vec%0d", i), vecs[i].addr, vecs[i].valid, vecs[i].done);
      chk($sformatf("vec%0d.slot", i), 32'(addr_slot), 32'(vecs[i].aslot));
    end

    // Clamped rate R=63: done on the 19th visit after key-on.
    beat(1'b1, 5'd10, 1'b1, 4'd14, 4'd15);
    chk_out("clamp.edge", 22'd0, 1'b1, 1'b0);
    for (int n = 1; n <= 19; n++) begin
      beat(1'b1, 5'd10, 1'b1, 4'd14, 4'd15);
      if (n < 19) chk_out("clamp.step", 22'(229376 * n), 1'b1, 1'b0);
      else        chk_out("clamp.final", 22'h3FFFFF, 1'b1, 1'b1);
    end
    beat(1'b1, 5'd10, 1'b1, 4'd14, 4'd15);
    chk_out("clamp.after", 22'h3FFFFF, 1'b0, 1'b0);

    // Nominal attack on slot 3, step 1024.
    beat(1'b1, 5'd3, 1'b1, 4'd8, 4'd0);
    chk_out("nom.edge", 22'd0, 1'b1, 1'b0);
    for (int n = 1; n <= 4096; n++) begin
      beat(1'b1, 5'd3, 1'b1, 4'd8, 4'd0);
      if (n < 4096) begin
        chk("nom.addr", 32'(addr), 32'(1024 * n));
        chk("nom.done", 32'(attack_done), 32'd0);
      end else begin
        chk_out("nom.final", 22'h3FFFFF, 1'b1, 1'b1);
      end
    end
    beat(1'b1, 5'd3, 1'b1, 4'd8, 4'd0);
    chk_out("nom.after", 22'h3FFFFF, 1'b0, 1'b0);

    // Key-off mid-attack, re-key, then asynchronous reset mid-attack on slot 7.
    beat(1'b1, 5'd7, 1'b1, 4'd8, 4'd0);
    for (int n = 1; n <= 5; n++) beat(1'b1, 5'd7, 1'b1, 4'd8, 4'd0);
    chk_out("k7.run", 22'd5120, 1'b1, 1'b0);
    beat(1'b1, 5'd7, 1'b0, 4'd8, 4'd0);
    chk_out("k7.off", 22'd5120, 1'b0, 1'b0);
    beat(1'b1, 5'd7, 1'b0, 4'd8, 4'd0);
    chk_out("k7.held", 22'd5120, 1'b0, 1'b0);
    beat(1'b1, 5'd7, 1'b1, 4'd8, 4'd0);
    chk_out("k7.rekey", 22'd0, 1'b1, 1'b0);
    beat(1'b1, 5'd7, 1'b1, 4'd8, 4'd0);
    chk_out("k7.step", 22'd1024, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk_out("k7.async", 22'd0, 1'b0, 1'b0);
    chk("k7.async.slot", 32'(addr_slot), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    beat(1'b1, 5'd7, 1'b0, 4'd8, 4'd0);
    chk_out("k7.post", 22'd0, 1'b0, 1'b0);
    beat(1'b1, 5'd7, 1'b1, 4'd8, 4'd0);
    chk_out("k7.post_edge", 22'd0, 1'b1, 1'b0);

    // Alignment under random clkena gaps; ar=0 keeps every valid slot in ATTACK.
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    nbeats = 0;
    for (int it = 0; it < 150; it++) begin
      en_pick = (it == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      s_pick  = 5'($urandom_range(0, 18));
      if (s_pick == 5'd18) s_pick = 5'd20;
      beat(en_pick, s_pick, 1'b1, 4'd0, 4'd0);
      if (en_pick) begin
        hist[nbeats] = int'(s_pick);
        nbeats++;
      end
      exp_as = 5'(hist[nbeats-1]);
      exp_av = (hist[nbeats-1] < 18);
      if (nbeats >= 3) begin
        exp_ds = 5'(hist[nbeats-3]);
        exp_dv = (hist[nbeats-3] < 18);
      end else begin
        exp_ds = '0;
        exp_dv = 1'b0;
      end
      chk("al.aslot", 32'(addr_slot), 32'(exp_as));
      chk("al.avalid", 32'(addr_valid), 32'(exp_av));
      chk("al.addr", 32'(addr), 32'd0);
      chk("al.dslot", 32'(data_slot), 32'(exp_ds));
      chk("al.dvalid", 32'(data_valid), 32'(exp_dv));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/attack_phase_sequencer.md
Name: attack_phase_sequencer

Overview:
- Time-multiplexed per-slot attack phase generator for the VM2413 envelope path.
- Sits directly upstream of AttackTable. It drives AttackTable's 22-bit address (7 integer + 15 fraction bits), one slot per clkena beat.
- Keeps per-slot attack phase and stage state internally.
- Delays slot identity to line up with AttackTable's 2-beat data latency, so the downstream envelope stage knows which slot each table result belongs to.

Parameters:
- NUM_SLOTS, 18, number of time-multiplexed operator slots; slot ids 0..NUM_SLOTS-1.
- PHASE_W, 22, attack phase width; must equal the AttackTable address width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clkena  in  1  beat enable; all state advances only when it is 1.
- slot  in  5  current slot id from the upstream slot counter.
- key  in  1  key-on level for the current slot.
- ar  in  4  attack rate register for the current slot.
- rks  in  4  rate key-scale offset for the current slot.
- addr  out  22  attack phase to AttackTable addr.
- addr_slot  out  5  slot id belonging to addr.
- addr_valid  out  1  addr slot is in ATTACK stage.
- attack_done  out  1  one-beat pulse: addr slot finished attack this beat.
- data_slot  out  5  slot id aligned with AttackTable data.
- data_valid  out  1  addr_valid delayed to align with AttackTable data.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Per-slot phase = 0, stage = IDLE, prev_key = 0.
  - All outputs = 0.
  - Takes effect immediately, including mid-attack.
  - After release, all slots behave as never keyed.
- clkena=0: every register and output holds.
- Per clkena beat, the block samples slot/key/ar/rks and processes that slot.
- slot >= NUM_SLOTS:
  - No state change.
  - addr_valid=0, attack_done=0, addr_slot=slot, addr=0.
- Per-slot state: phase[21:0], stage in {IDLE, ATTACK, DONE}, prev_key.
- Effective rate R[5:0] = min(ar*4 + rks, 63).
- Step:
  - ar=0: step = 0.
  - otherwise: step = {1'b1, R[1:0]} << R[5:2], i.e. (4+R[1:0]) * 2^R[5:2]; max 7*2^15.
- Priority, highest first:
  1. Key-on edge (key=1, prev_key=0), ar<15: phase=0, stage=ATTACK. The beat's output addr is 0 (no step applied this beat).
  2. Key-on edge with ar=15: phase=0x3FFFFF, stage=DONE, attack_done=1. Instant attack.
  3. key=0: stage=IDLE, phase held (release is owned downstream).
  4. stage=ATTACK, key=1:
     - sum = phase + step, computed at 23 bits.
     - If sum >= 0x3FFFFF: phase=0x3FFFFF, stage=DONE, attack_done=1.
     - Otherwise phase = sum.
  5. stage IDLE or DONE with key=1, no edge: no change.
- prev_key is updated with key every valid-slot beat.
- A key-on edge on a slot already in ATTACK or DONE restarts it from phase 0.
- Outputs are registered, 1 clkena beat after the inputs:
  - addr = the slot's new phase.
  - addr_slot = slot.
  - addr_valid = (new stage == ATTACK) or attack_done.
- data_slot/data_valid:
  - addr_slot/addr_valid delayed by 2 further clkena beats, matching AttackTable's addr-to-data latency.
  - Total input-to-data_slot latency is 3 beats.
- Storage: an 18-entry register array or distributed RAM; read and write of the same slot happen within the one beat.

Test Plan:
- Reset then idle: reset_n pulse with clkena toggling and key=0 on all slots -> addr=0, addr_valid=0, attack_done=0, data_valid=0 throughout.
- Nominal attack, slot 3, ar=8, rks=0 (R=32, step=1024):
  - Key-on edge -> addr=0 on that beat.
  - n-th subsequent visit -> addr=1024*n.
  - 4096th visit -> addr=0x3FFFFF with a single attack_done pulse; later visits give addr_valid=0.
- Instant attack, slot 5, ar=15: key-on edge -> the same beat's output gives addr=0x3FFFFF, attack_done=1, addr_valid=1; the next visit gives addr_valid=0.
- Rate clamp and zero rate:
  - ar=14, rks=15 -> R=63, step=7<<15=229376; done on the 19th visit.
  - ar=0 -> addr stays 0 and addr_valid=1 indefinitely.
- Key-off mid-attack then re-key, slot 7:
  - key=0 at phase 5120 -> addr_valid=0, phase held.
  - key=1 edge -> phase restarts at 0.
  - Async reset asserted mid-attack -> outputs 0 immediately; no attack_done after release.
- Alignment and gating:
  - Random clkena gaps with slots 0..17 plus slot 20 -> data_slot/data_valid equal addr_slot/addr_valid exactly 2 enabled beats later.
  - Slot 20 never changes state or asserts valid.
  - No output changes while clkena=0.
